ram_bus_arbiter: RTL and testbench

//  Shares the single RAM port between two cores' cache request channels (icache + dcache each).

---
 rtl/ram_bus_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_ram_bus_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter
//   Shares one RAM port between two cores, each with an instruction and a
//   data cache request channel. Data requests outrank instruction requests;
//   within a class, ties go round-robin between the cores. A granted
//   transaction owns the RAM port until the RAM reports ACCESS.
//
// Optional feature: define ARB_STATS_EN to add CNT_W-wide saturating
//   completion counters on grant_cnt (index 0 c0d, 1 c1d, 2 c0i, 3 c1i).
//
// Ports
//   CLK, nRST          clock (rising edge), async active-low reset
//   iREN/dREN/dWEN     per-core instruction read / data read / data write requests
//   iaddr/daddr/dstore per-core addresses and write data
//   iwait/dwait        per-core wait (0 = transaction completes this cycle)
//   iload/dload        per-core read data (0 unless completing a read)
//   ramstate/ramload   RAM status (FREE/BUSY/ACCESS/ERROR) and read data
//   ramaddr/ramstore   RAM address and write data
//   ramREN/ramWEN      RAM read / write enables
//   grant_cnt          completion counters (ARB_STATS_EN only)
module ram_bus_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
`ifdef ARB_STATS_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [1:0]        iREN,
  input  logic [1:0]        dREN,
  input  logic [1:0]        dWEN,
  input  logic [ADDR_W-1:0] iaddr  [2],
  input  logic [ADDR_W-1:0] daddr  [2],
  input  logic [DATA_W-1:0] dstore [2],
  output logic [1:0]        iwait,
  output logic [1:0]        dwait,
  output logic [DATA_W-1:0] iload  [2],
  output logic [DATA_W-1:0] dload  [2],
  input  logic [1:0]        ramstate,
  input  logic [DATA_W-1:0] ramload,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  output logic              ramREN,
  output logic              ramWEN
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt [4]
`endif
);

  localparam logic [1:0] RamAccess = 2'd2;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e state_q, state_d;
  // Latched winner: owning core, class (1 = instruction) and direction.
  logic   core_q,  core_d;
  logic   instr_q, instr_d;
  logic   wr_q,    wr_d;
  // Round-robin pointers: core that wins a tie in each class.
  logic   dptr_q,  dptr_d;
  logic   iptr_q,  iptr_d;

  logic       live_en;   // winner still asserting the enable it was granted on
  logic       active;    // GRANT with a live winner: RAM port is driven
  logic       done;      // completion this cycle
  logic [1:0] dreq_m;
  logic [1:0] ireq_m;
  logic       dptr_arb;
  logic       iptr_arb;
  logic       arb_valid;
  logic       arb_core;
  logic       arb_instr;
  logic       arb_wr;

  always_comb begin
    if (instr_q) begin
      live_en = iREN[core_q];
    end else if (wr_q) begin
      live_en = dWEN[core_q];
    end else begin
      live_en = dREN[core_q];
    end
    active = (state_q == StGrant) && live_en;
    done   = active && (ramstate == RamAccess);
  end

  // Arbitration. On a completing edge the finished requester is masked out
  // (its enable is still high until the core sees wait=0) and the pointer
  // for its class is already flipped, so back-to-back grants stay fair.
  always_comb begin
    dreq_m   = dREN | dWEN;
    ireq_m   = iREN;
    dptr_arb = dptr_q;
    iptr_arb = iptr_q;
    if (done) begin
      if (instr_q) begin
        ireq_m[core_q] = 1'b0;
        iptr_arb       = ~core_q;
      end else begin
        dreq_m[core_q] = 1'b0;
        dptr_arb       = ~core_q;
      end
    end
    arb_valid = (|dreq_m) || (|ireq_m);
    arb_core  = 1'b0;
    arb_instr = 1'b0;
    arb_wr    = 1'b0;
    if (|dreq_m) begin
      arb_core = (dreq_m == 2'b11) ? dptr_arb : dreq_m[1];
      arb_wr   = dWEN[arb_core];
    end else if (|ireq_m) begin
      arb_instr = 1'b1;
      arb_core  = (ireq_m == 2'b11) ? iptr_arb : ireq_m[1];
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      core_q  <= 1'b0;
      instr_q <= 1'b0;
      wr_q    <= 1'b0;
      dptr_q  <= 1'b0;
      iptr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
      instr_q <= instr_d;
      wr_q    <= wr_d;
      dptr_q  <= dptr_d;
      iptr_q  <= iptr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    core_d  = core_q;
    instr_d = instr_q;
    wr_d    = wr_q;
    dptr_d  = dptr_q;
    iptr_d  = iptr_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          state_d = StGrant;
          core_d  = arb_core;
          instr_d = arb_instr;
          wr_d    = arb_wr;
        end
      end
      StGrant: begin
        if (!live_en) begin
          // Abort: winner withdrew; pointers untouched.
          state_d = StIdle;
        end else if (done) begin
          dptr_d = dptr_arb;
          iptr_d = iptr_arb;
          if (arb_valid) begin
            core_d  = arb_core;
            instr_d = arb_instr;
            wr_d    = arb_wr;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: RAM port follows the winner's live inputs; loads pass through
  // combinationally only in the completing cycle.
  always_comb begin
    iwait    = 2'b11;
    dwait    = 2'b11;
    iload[0] = '0;
    iload[1] = '0;
    dload[0] = '0;
    dload[1] = '0;
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    if (active) begin
      if (instr_q) begin
        ramaddr = iaddr[core_q];
        ramREN  = 1'b1;
      end else begin
        ramaddr  = daddr[core_q];
        ramstore = dstore[core_q];
        ramREN   = ~wr_q;
        ramWEN   = wr_q;
      end
    end
    if (done) begin
      if (instr_q) begin
        iwait[core_q] = 1'b0;
        iload[core_q] = ramload;
      end else begin
        dwait[core_q] = 1'b0;
        if (!wr_q) begin
          dload[core_q] = ramload;
        end
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [1:0] cnt_idx;
  assign cnt_idx = {instr_q, core_q};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < 4; k++) begin
        grant_cnt[k] <= '0;
      end
    end else if (done && (grant_cnt[cnt_idx] != '1)) begin
      grant_cnt[cnt_idx] <= grant_cnt[cnt_idx] + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_bus_arbiter.sv
module tb_ram_bus_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  iREN, dREN, dWEN;
  logic [31:0] iaddr [2];
  logic [31:0] daddr [2];
  logic [31:0] dstore [2];
  logic [1:0]  iwait, dwait;
  logic [31:0] iload [2];
  logic [31:0] dload [2];
  logic [1:0]  ramstate;
  logic [31:0] ramload, ramaddr, ramstore;
  logic        ramREN, ramWEN;
`ifdef ARB_STATS_EN
  logic [2:0]  grant_cnt [4];
`endif

  ram_bus_arbiter #(
    .ADDR_W(32),
    .DATA_W(32)
`ifdef ARB_STATS_EN
    , .CNT_W(3)
`endif
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .iaddr    (iaddr),
    .daddr    (daddr),
    .dstore   (dstore),
    .iwait    (iwait),
    .dwait    (dwait),
    .iload    (iload),
    .dload    (dload),
    .ramstate (ramstate),
    .ramload  (ramload),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN)
`ifdef ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // RAM model: BUSY for `lat` cycles, then ACCESS for one cycle.
  logic [31:0] mem [256];
  int unsigned lat = 0;
  int unsigned ram_cnt = 0;

  always_comb begin
    ramload = mem[ramaddr[9:2]];
    if (!(ramREN || ramWEN))  ramstate = 2'd0;
    else if (ram_cnt >= lat)  ramstate = 2'd2;
    else                      ramstate = 2'd1;
  end

  always @(posedge CLK) begin
    if (ramstate == 2'd2 && ramWEN) mem[ramaddr[9:2]] <= ramstore;
    if (ramstate != 2'd1) ram_cnt <= 0;
    else                  ram_cnt <= ram_cnt + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        core;
    logic        instr;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] load;
  } exp_t;

  exp_t sb [$];

  // Scoreboard: every completion pops one expected transaction.
  exp_t        mon_e;
  logic [1:0]  exp_iw, exp_dw;
  logic [31:0] exp_il [2];
  logic [31:0] exp_dl [2];

  always @(negedge CLK) begin
    if (nRST && (iwait != 2'b11 || dwait != 2'b11)) begin
      check("one_done", 128'($countones(~{iwait, dwait})), 128'(1));
      if (sb.size() == 0) begin
        check("unexpected_done", {iwait, dwait}, 4'hF);
      end else begin
        mon_e  = sb.pop_front();
        exp_iw = 2'b11;
        exp_dw = 2'b11;
        exp_il[0] = '0; exp_il[1] = '0;
        exp_dl[0] = '0; exp_dl[1] = '0;
        if (mon_e.instr) begin
          exp_iw[mon_e.core] = 1'b0;
          exp_il[mon_e.core] = mon_e.load;
        end else begin
          exp_dw[mon_e.core] = 1'b0;
          if (!mon_e.wr) exp_dl[mon_e.core] = mon_e.load;
        end
        check("waits", {iwait, dwait}, {exp_iw, exp_dw});
        check("ramaddr", ramaddr, mon_e.addr);
        check("ren_wen", {ramREN, ramWEN}, {~mon_e.wr, mon_e.wr});
        if (mon_e.wr) check("ramstore", ramstore, mon_e.wdata);
        check("loads", {iload[1], iload[0], dload[1], dload[0]},
              {exp_il[1], exp_il[0], exp_dl[1], exp_dl[0]});
      end
    end
  end

  task automatic idle_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    for (int c = 0; c < 2; c++) begin
      iaddr[c] = '0; daddr[c] = '0; dstore[c] = '0;
    end
  endtask

  task automatic wait_done(input logic instr, input logic core, input string name);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge CLK);
      if ((instr ? iwait[core] : dwait[core]) == 1'b0) seen = 1;
    end
    if (!seen) check(name, instr ? iwait[core] : dwait[core], 0);
  endtask

  task automatic wait_n_done(input int n, input string name);
    int cnt = 0;
    for (int i = 0; i < 100 && cnt < n; i++) begin
      @(negedge CLK);
      if (iwait != 2'b11 || dwait != 2'b11) cnt++;
    end
    if (cnt < n) check(name, cnt, n);
  endtask

  // One isolated transaction: drive, expect, wait for completion, release.
  task automatic issue(input logic core, input logic instr, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int unsigned l, input logic [31:0] load);
    @(posedge CLK); #1;
    idle_inputs();
    lat = l;
    if (instr) begin
      iREN[core] = 1'b1; iaddr[core] = addr;
    end else begin
      daddr[core] = addr; dstore[core] = wdata;
      if (wr) dWEN[core] = 1'b1; else dREN[core] = 1'b1;
    end
    sb.push_back('{core, instr, wr, addr, wdata, load});
    wait_done(instr, core, "txn_timeout");
    @(posedge CLK); #1;
    idle_inputs();
  endtask

  typedef struct {
    logic        core;
    logic        instr;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned l;
    logic [31:0] exp_load;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0F0, 32'hDAD1DAD1, 1, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0F0, 32'h0,        0, 32'hDAD1DAD1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h010, 32'h0,        2, 32'hA5000004};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h088, 32'h0,        0, 32'hA5000022};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h020, 32'h12345678, 3, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h020, 32'h0,        1, 32'h12345678};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h020, 32'h0,        0, 32'h12345678};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h3FC, 32'h0,        1, 32'hA50000FF};

    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
    idle_inputs();
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_waits", {iwait, dwait}, 4'hF);
    check("rst_en", {ramREN, ramWEN}, 2'b00);
    check("rst_addr_store", {ramaddr, ramstore}, 64'h0);
    check("rst_loads", {iload[1], iload[0], dload[1], dload[0]}, 128'h0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].core, vecs[i].instr, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
            vecs[i].l, vecs[i].exp_load);
    end

    // Data beats instruction; instruction follows with no idle cycle.
    @(posedge CLK); #1;
    lat = 1;
    iREN[0] = 1'b1; iaddr[0] = 32'h88;
    dREN[0] = 1'b1; daddr[0] = 32'h44;
    sb.push_back('{1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 32'hA5000011});
    sb.push_back('{1'b0, 1'b1, 1'b0, 32'h88, 32'h0, 32'hA5000022});
    wait_done(1'b0, 1'b0, "dfirst_timeout");
    @(posedge CLK); #1;
    dREN[0] = 1'b0;
    check("no_bubble", {ramREN, ramaddr}, {1'b1, 32'h88});
    wait_done(1'b1, 1'b0, "ifollow_timeout");
    @(posedge CLK); #1;
    idle_inputs();

    // Reset during GRANT clears outputs asynchronously.
    lat = 20;
    dREN[1] = 1'b1; daddr[1] = 32'h40;
    @(posedge CLK); @(posedge CLK); #1;
    check("grant_before_rst", {ramREN, ramaddr}, {1'b1, 32'h40});
    #2 nRST = 1'b0;
    #1;
    check("async_rst_en", {ramREN, ramWEN}, 2'b00);
    check("async_rst_addr", ramaddr, 32'h0);
    check("async_rst_waits", {iwait, dwait}, 4'hF);
    idle_inputs();
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    // Both cores hold dREN: completions alternate starting at core0.
    @(posedge CLK); #1;
    lat = 1;
    dREN = 2'b11; daddr[0] = 32'h100; daddr[1] = 32'h104;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'hA5000040});
      sb.push_back('{1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 32'hA5000041});
    end
    wait_n_done(4, "rr_timeout");
    @(posedge CLK); #1;
    idle_inputs();

    // Abort: c1 drops dREN while BUSY; pointer must not move.
    @(posedge CLK); #1;
    lat = 10;
    dREN[1] = 1'b1; daddr[1] = 32'h200;
    @(posedge CLK); @(posedge CLK); #1;
    check("abort_granted", {ramREN, ramaddr}, {1'b1, 32'h200});
    dREN[1] = 1'b0;
    @(posedge CLK); #1;
    check("abort_ren_low", {ramREN, ramWEN}, 2'b00);
    lat = 0;
    dREN = 2'b11; daddr[0] = 32'h300; daddr[1] = 32'h304;
    sb.push_back('{1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 32'hA50000C0});
    sb.push_back('{1'b1, 1'b0, 1'b0, 32'h304, 32'h0, 32'hA50000C1});
    wait_n_done(2, "post_abort_timeout");
    @(posedge CLK); #1;
    idle_inputs();

`ifdef ARB_STATS_EN
    nRST = 1'b0;
    #1;
    nRST = 1'b1;
    for (int k = 0; k < 3; k++) issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1, 32'hA5000000);
    @(posedge CLK); #1;
    lat = 10;
    dREN[0] = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    idle_inputs();
    @(posedge CLK); #1;
    check("cnt_c0d", grant_cnt[0], 3);
    check("cnt_others", {grant_cnt[3], grant_cnt[2], grant_cnt[1]}, 9'h0);
    for (int k = 0; k < 5; k++) issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'hA5000000);
    @(posedge CLK); #1;
    check("cnt_saturate", grant_cnt[0], 7);
`endif

    repeat (3) @(posedge CLK);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
